// File: rtl/ddr3_user_port_arbiter.sv
// Two-port round-robin front end for ddr3_memory_controller: one command in flight,
// reads wait for data (or a timeout) before the next port is granted.
module ddr3_user_port_arbiter #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int RD_TIMEOUT            = 1023
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              p0_req,
  input  logic                                              p1_req,
  input  logic                                              p0_we,
  input  logic                                              p1_we,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] p0_addr,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] p1_addr,
  input  logic [DQ_BITWIDTH-1:0]                            p0_wdata,
  input  logic [DQ_BITWIDTH-1:0]                            p1_wdata,
  output logic                                              p0_ack,
  output logic                                              p1_ack,
  output logic                                              p0_rvalid,
  output logic                                              p1_rvalid,
  output logic [DQ_BITWIDTH-1:0]                            rdata,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  input  logic                                              ctrl_cmd_ready,
  input  logic                                              ctrl_rd_valid,
  output logic                                              owner,
  output logic                                              busy,
  output logic                                              rd_timeout_err,
  output logic [1:0]                                        dbg_state
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(RD_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } state_t;

  // Handshakes: a port holds req and its fields until it sees its one-cycle ack;
  // the command strobe is held with stable address/data until ctrl_cmd_ready is
  // sampled high on a rising edge, which is the transfer edge.
  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DQ_BITWIDTH-1:0] wdata_q, wdata_d;
  logic [DQ_BITWIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       req_eff;
  logic             grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= 2'b00;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    // A port whose ack is still showing is finishing its handshake, not asking again.
    req_eff  = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};
    grant    = (req_eff == 2'b11) ? prio_q : req_eff[1];
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    ack_d    = 2'b00;
    rvalid_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req_eff) begin
          state_d = S_ISSUE;
          owner_d = grant;
          prio_d  = ~grant;
          we_d    = grant ? p1_we    : p0_we;
          addr_d  = grant ? p1_addr  : p0_addr;
          wdata_d = grant ? p1_wdata : p0_wdata;
        end
      end
      S_ISSUE: begin
        if (ctrl_cmd_ready) begin
          ack_d[owner_q] = 1'b1;
          cnt_d          = '0;
          state_d        = we_q ? S_IDLE : S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (ctrl_rd_valid) begin
          rdata_d           = data_from_ram;
          rvalid_d[owner_q] = 1'b1;
          state_d           = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d             = 1'b1;
          rdata_d           = '0;
          rvalid_d[owner_q] = 1'b1;
          state_d           = S_IDLE;
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    write_enable        = (state_q == S_ISSUE) && we_q;
    read_enable         = (state_q == S_ISSUE) && !we_q;
    busy                = (state_q != S_IDLE);
    dbg_state           = state_q;
    owner               = owner_q;
    i_user_data_address = addr_q;
    data_to_ram         = wdata_q;
    rdata               = rdata_q;
    rd_timeout_err      = err_q;
    p0_ack              = ack_q[0];
    p1_ack              = ack_q[1];
    p0_rvalid           = rvalid_q[0];
    p1_rvalid           = rvalid_q[1];
  end

endmodule

// File: doc/ddr3_user_port_arbiter.md
DDR3_USER_PORT_ARBITER -- requirements
Module: ddr3_user_port_arbiter

Parameters
REQ-001 The block SHALL have parameter ADDRESS_BITWIDTH, default 15, which is the DDR3 row/column address width.
REQ-002 The block SHALL have parameter BANK_ADDRESS_BITWIDTH, default 3, which is the bank address width.
REQ-003 The block SHALL have parameter DQ_BITWIDTH, default 16, which is the user data width.
REQ-004 The block SHALL have parameter RD_TIMEOUT, default 1023, which is the maximum number of cycles to wait for read data.
REQ-005 AW SHALL denote BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH throughout this document.

Interface
REQ-006 The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-008 The block SHALL have ports p0_req and p1_req, input, width 1 each: request from requester 0/1; held with its fields until that port's ack.
REQ-009 The block SHALL have ports p0_we and p1_we, input, width 1 each: 1 = write, 0 = read.
REQ-010 The block SHALL have ports p0_addr and p1_addr, input, width AW each: {bank, address} of the request.
REQ-011 The block SHALL have ports p0_wdata and p1_wdata, input, width DQ_BITWIDTH each: write data.
REQ-012 The block SHALL have ports p0_ack and p1_ack, output, width 1 each: one-cycle pulse when the controller accepts that port's command.
REQ-013 The block SHALL have ports p0_rvalid and p1_rvalid, output, width 1 each: one-cycle pulse with valid rdata for that port.
REQ-014 The block SHALL have port rdata, output, width DQ_BITWIDTH: read data, shared by both ports.
REQ-015 The block SHALL have ports write_enable and read_enable, output, width 1 each: command strobes to ddr3_memory_controller.
REQ-016 The block SHALL have port i_user_data_address, output, width AW: address to the controller.
REQ-017 The block SHALL have port data_to_ram, output, width DQ_BITWIDTH: write data to the controller.
REQ-018 The block SHALL have port data_from_ram, input, width DQ_BITWIDTH: read data from the controller.
REQ-019 The block SHALL have port ctrl_cmd_ready, input, width 1: the controller accepts the presented command this cycle.
REQ-020 The block SHALL have port ctrl_rd_valid, input, width 1: data_from_ram is valid this cycle.
REQ-021 The block SHALL have port owner, output, width 1: index of the port currently being served.
REQ-022 The block SHALL have port busy, output, width 1: the FSM is not in IDLE.
REQ-023 The block SHALL have port rd_timeout_err, output, width 1: sticky read-timeout flag.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_RD.
REQ-025 In IDLE with any req high, the block SHALL select a port, latch that port's we/addr/wdata into internal registers, set owner, and enter ISSUE on the next cycle.
REQ-026 Selection SHALL be round-robin: if only one port requests, that port is served; if both request, the port not served last is served; after reset port 0 has priority.
REQ-027 In ISSUE, the block SHALL hold write_enable or read_enable high (per the latched we), together with the latched i_user_data_address and data_to_ram, every cycle until ctrl_cmd_ready=1.
REQ-028 When the ISSUE command is accepted, the block SHALL pulse p<owner>_ack for one cycle, coincident with the accepting edge plus one.
REQ-029 In the cycle after acceptance, the command strobe SHALL be low.
REQ-030 After an accepted write, the FSM SHALL return to IDLE.
REQ-031 After an accepted read, the FSM SHALL go to WAIT_RD.
REQ-032 In WAIT_RD, on ctrl_rd_valid=1 the block SHALL register data_from_ram into rdata, pulse p<owner>_rvalid for one cycle, and return to IDLE.
REQ-033 rdata SHALL hold its value until the next capture.
REQ-034 In WAIT_RD, if RD_TIMEOUT cycles elapse without ctrl_rd_valid, the block SHALL set rd_timeout_err, pulse p<owner>_rvalid with rdata=0, and return to IDLE.
REQ-035 rd_timeout_err SHALL be cleared only by reset.
REQ-036 The timeout counter SHALL be ceil(log2(RD_TIMEOUT+1)) bits wide, cleared on WAIT_RD entry, and non-wrapping (saturating).
REQ-037 ctrl_rd_valid seen outside WAIT_RD SHALL be ignored: no rvalid pulse and rdata unchanged.
REQ-038 ctrl_cmd_ready seen outside ISSUE SHALL be ignored.
REQ-039 At most one command SHALL be outstanding; requests arriving while busy=1 SHALL wait.
REQ-040 A request from the served port re-asserted in the same cycle as IDLE re-entry SHALL be arbitrated normally and SHALL NOT preempt a waiting other port.
REQ-041 write_enable and read_enable SHALL never be high simultaneously.
REQ-042 busy SHALL be 1 in ISSUE and WAIT_RD.

Reset
REQ-043 When reset is asserted, the block SHALL asynchronously force the FSM to IDLE and set write_enable=0, read_enable=0, i_user_data_address=0, data_to_ram=0, rdata=0, p0_ack=p1_ack=0, p0_rvalid=p1_rvalid=0, owner=0, busy=0, rd_timeout_err=0, the round-robin pointer to port 0 priority, and the timeout counter to 0.
REQ-044 Reset asserted mid-ISSUE or mid-WAIT_RD SHALL abandon the command without any ack or rvalid.
REQ-045 After reset deassertion, the first arbitration SHALL occur at the first clk edge with a req high.

Verification
REQ-046 Bench scenario: p0 write addr=0x00005, wdata=0x1234, ctrl_cmd_ready high after 3 cycles -> write_enable high 3 cycles with addr/data stable; p0_ack one pulse; busy drops.
REQ-047 Bench scenario: p0 and p1 request reads simultaneously from reset -> p0 served first, then p1; rvalid pulses on data_from_ram=0xAAAA then 0x5555 with correct rdata.
REQ-048 Bench scenario: p1 requests continuously while p0 requests -> grants alternate p1, p0, p1, ...; neither port is starved.
REQ-049 Bench scenario: read accepted, no ctrl_rd_valid for RD_TIMEOUT cycles -> rd_timeout_err=1 (sticky), rvalid with rdata=0, FSM in IDLE.
REQ-050 Bench scenario: reset pulsed in WAIT_RD -> all outputs at reset values immediately; a later ctrl_rd_valid produces no rvalid.
REQ-051 Bench scenario: ctrl_rd_valid and ctrl_cmd_ready pulsed in IDLE -> no ack, no rvalid, rdata unchanged.
